// File: rtl/byte_unit_pkg.sv
// Shared constants, opcode decode and writeback record for byte_unit.
// Optional sumb support is selected by the BYTE_UNIT_SUMB_EN macro.
package byte_unit_pkg;

  localparam int OP_W   = 11;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 128;
  localparam int IMM_W  = 18;

  localparam logic [0:OP_W-1] OP_CNTB  = 11'b01010110100;
  localparam logic [0:OP_W-1] OP_AVGB  = 11'b00011010011;
  localparam logic [0:OP_W-1] OP_ABSDB = 11'b00001010011;
  localparam logic [0:OP_W-1] OP_SUMB  = 11'b01001010011;
  localparam logic [2:0]      FMT_RR   = 3'b000;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CNTB,
    SEL_AVGB,
    SEL_ABSDB,
    SEL_SUMB
  } op_sel_e;

  // Without the sumb build option its opcode decodes like any unknown op.
`ifdef BYTE_UNIT_SUMB_EN
  localparam op_sel_e SUMB_SEL = SEL_SUMB;
`else
  localparam op_sel_e SUMB_SEL = SEL_NONE;
`endif

  typedef struct packed {
    logic [0:DATA_W-1] data;
    logic [0:ADDR_W-1] addr;
    logic              we;
  } wb_t;

  function automatic op_sel_e decode_op(input logic [0:OP_W-1] op,
                                        input logic [2:0]      fmt);
    decode_op = SEL_NONE;
    if (fmt == FMT_RR) begin
      case (op)
        OP_CNTB:  decode_op = SEL_CNTB;
        OP_AVGB:  decode_op = SEL_AVGB;
        OP_ABSDB: decode_op = SEL_ABSDB;
        OP_SUMB:  decode_op = SUMB_SEL;
        default:  decode_op = SEL_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/byte_unit_lane.sv
// One byte lane: popcount, rounded average and absolute difference.
module byte_unit_lane (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] cnt,
  output logic [7:0] avg,
  output logic [7:0] absd
);

  logic [3:0] ones;
  logic [8:0] avg_sum;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, a[i]};
  end

  assign cnt     = {4'b0000, ones};
  assign avg_sum = {1'b0, a} + {1'b0, b} + 9'd1;
  assign avg     = avg_sum[8:1];
  assign absd    = (b >= a) ? (b - a) : (a - b);

endmodule

// File: rtl/byte_unit.sv
// Byte-wise SIMD unit with a LATENCY-deep writeback pipeline.
// sumb is built only when BYTE_UNIT_SUMB_EN is defined.
module byte_unit
  import byte_unit_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:OP_W-1]   op,
  input  logic [2:0]        format,
  input  logic [0:ADDR_W-1] rt_addr,
  input  logic [0:DATA_W-1] ra,
  input  logic [0:DATA_W-1] rb,
  input  logic [0:IMM_W-1]  imm,
  input  logic              reg_write,
  output logic [0:DATA_W-1] rt_wb,
  output logic [0:ADDR_W-1] rt_addr_wb,
  output logic              reg_write_wb
);

  localparam int NB = DATA_W / 8;

  op_sel_e           op_sel;
  logic [0:DATA_W-1] result;
  logic [7:0]        cnt_b  [NB];
  logic [7:0]        avg_b  [NB];
  logic [7:0]        absd_b [NB];
  wb_t               pipe_d [LATENCY];
  wb_t               pipe_q [LATENCY];

  // No supported op reads the immediate.
  logic unused_imm;
  assign unused_imm = ^imm;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    byte_unit_lane u_lane (
      .a    (ra[8*k +: 8]),
      .b    (rb[8*k +: 8]),
      .cnt  (cnt_b[k]),
      .avg  (avg_b[k]),
      .absd (absd_b[k])
    );
  end

`ifdef BYTE_UNIT_SUMB_EN
  logic [9:0]        sum_a [DATA_W/32];
  logic [9:0]        sum_b [DATA_W/32];
  logic [0:DATA_W-1] sumb_res;

  always_comb begin
    sumb_res = '0;
    for (int w = 0; w < DATA_W/32; w++) begin
      sum_a[w] = {2'b00, ra[32*w +: 8]}    + {2'b00, ra[32*w+8 +: 8]}
               + {2'b00, ra[32*w+16 +: 8]} + {2'b00, ra[32*w+24 +: 8]};
      sum_b[w] = {2'b00, rb[32*w +: 8]}    + {2'b00, rb[32*w+8 +: 8]}
               + {2'b00, rb[32*w+16 +: 8]} + {2'b00, rb[32*w+24 +: 8]};
      sumb_res[32*w +: 16]    = {6'b000000, sum_b[w]};
      sumb_res[32*w+16 +: 16] = {6'b000000, sum_a[w]};
    end
  end
`endif

  always_comb begin
    op_sel = decode_op(op, format);
    result = '0;
    for (int k = 0; k < NB; k++) begin
      case (op_sel)
        SEL_CNTB:  result[8*k +: 8] = cnt_b[k];
        SEL_AVGB:  result[8*k +: 8] = avg_b[k];
        SEL_ABSDB: result[8*k +: 8] = absd_b[k];
        default:   result[8*k +: 8] = 8'h00;
      endcase
    end
`ifdef BYTE_UNIT_SUMB_EN
    if (op_sel == SEL_SUMB) result = sumb_res;
`endif
    // Unrecognized slots travel as bubbles: no data, no address, no write.
    pipe_d[0].data = result;
    pipe_d[0].addr = (op_sel != SEL_NONE) ? rt_addr : '0;
    pipe_d[0].we   = (op_sel != SEL_NONE) && reg_write;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign rt_wb        = pipe_q[LATENCY-1].data;
  assign rt_addr_wb   = pipe_q[LATENCY-1].addr;
  assign reg_write_wb = pipe_q[LATENCY-1].we;

endmodule

// File: tb/tb_byte_unit.sv
// Self-checking bench for byte_unit: directed vectors, reset flushes and
// randomized traffic against a behavioural model (honours BYTE_UNIT_SUMB_EN).
module tb_byte_unit;

  localparam int LAT = 3;

  localparam logic [0:10] T_CNTB  = 11'b01010110100;
  localparam logic [0:10] T_AVGB  = 11'b00011010011;
  localparam logic [0:10] T_ABSDB = 11'b00001010011;
  localparam logic [0:10] T_SUMB  = 11'b01001010011;

`ifdef BYTE_UNIT_SUMB_EN
  localparam bit SUMB_ON = 1'b1;
`else
  localparam bit SUMB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [0:10]  op = '0;
  logic [2:0]   format = '0;
  logic [0:6]   rt_addr = '0;
  logic [0:127] ra = '0;
  logic [0:127] rb = '0;
  logic [0:17]  imm = '0;
  logic         reg_write = 1'b0;
  logic [0:127] rt_wb;
  logic [0:6]   rt_addr_wb;
  logic         reg_write_wb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [0:127] data;
    logic [0:6]   addr;
    logic         we;
    logic         chk_addr;
    string        tag;
  } exp_t;

  exp_t q[$];

  byte_unit #(.LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .format       (format),
    .rt_addr      (rt_addr),
    .ra           (ra),
    .rb           (rb),
    .imm          (imm),
    .reg_write    (reg_write),
    .rt_wb        (rt_wb),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [0:127] d, input logic [0:6] a,
                              input logic w, input logic c, input string t);
    exp_t e;
    e.data = d; e.addr = a; e.we = w; e.chk_addr = c; e.tag = t;
    return e;
  endfunction

  function automatic bit recognized(input logic [0:10] o, input logic [2:0] f);
    if (f != 3'b000) return 1'b0;
    return (o == T_CNTB) || (o == T_AVGB) || (o == T_ABSDB) ||
           ((o == T_SUMB) && SUMB_ON);
  endfunction

  function automatic logic [0:127] model(input logic [0:10] o, input logic [2:0] f,
                                         input logic [0:127] a, input logic [0:127] b);
    logic [0:127] r;
    logic [0:7]   ab, bb;
    int           ai, bi, sa, sb;
    r = '0;
    if (!recognized(o, f)) return r;
    if (o == T_SUMB) begin
      for (int w = 0; w < 4; w++) begin
        sa = 0; sb = 0;
        for (int j = 0; j < 4; j++) begin
          ab = a[32*w + 8*j +: 8]; bb = b[32*w + 8*j +: 8];
          sa += int'(ab); sb += int'(bb);
        end
        r[32*w +: 16]    = 16'(sb);
        r[32*w+16 +: 16] = 16'(sa);
      end
      return r;
    end
    for (int k = 0; k < 16; k++) begin
      ab = a[8*k +: 8]; bb = b[8*k +: 8];
      ai = int'(ab); bi = int'(bb);
      if (o == T_CNTB)      r[8*k +: 8] = 8'($countones(ab));
      else if (o == T_AVGB) r[8*k +: 8] = 8'((ai + bi + 1) / 2);
      else                  r[8*k +: 8] = 8'((ai > bi) ? (ai - bi) : (bi - ai));
    end
    return r;
  endfunction

  task automatic set_in(input logic [0:10] o, input logic [2:0] f, input logic [0:6] a,
                        input logic [0:127] x, input logic [0:127] y, input logic w);
    op = o; format = f; rt_addr = a; ra = x; rb = y; reg_write = w;
    imm = 18'($urandom);
  endtask

  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert (rt_wb === e.data) else begin
      failures++;
      $error("FAIL %s rt_wb got=%h exp=%h", e.tag, rt_wb, e.data);
    end
    checks++;
    assert (reg_write_wb === e.we) else begin
      failures++;
      $error("FAIL %s reg_write_wb got=%b exp=%b", e.tag, reg_write_wb, e.we);
    end
    if (e.chk_addr) begin
      checks++;
      assert (rt_addr_wb === e.addr) else begin
        failures++;
        $error("FAIL %s rt_addr_wb got=%h exp=%h", e.tag, rt_addr_wb, e.addr);
      end
    end
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Reset at an edge empties every stage, so the next LAT slots are all zero.
  task automatic reset_step(input string t);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < LAT; i++) q.push_back(mk('0, '0, 1'b0, 1'b1, t));
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic model_step(input string t);
    step(mk(model(op, format, ra, rb), rt_addr,
            recognized(op, format) & reg_write, recognized(op, format), t));
  endtask

  localparam logic [0:127] VRA = 128'h0003000F000100010001000100010001;
  localparam logic [0:127] VRB = 128'h00FB0000000100010001000100010001;
  localparam logic [0:127] ONES = {128{1'b1}};

  initial begin
    logic [0:10]  ro;
    logic [2:0]   rf;
    logic [0:127] rx, ry;

    set_in(T_CNTB, 3'b000, 7'd3, VRA, VRB, 1'b1);
    reset_step("rst_hold0");
    reset_step("rst_hold1");
    reset = 1'b1;

    set_in(T_CNTB, 3'b000, 7'd3, VRA, VRB, 1'b1);
    step(mk(128'h00020004000100010001000100010001, 7'd3, 1'b1, 1'b1, "ver_cntb"));
    set_in(T_AVGB, 3'b000, 7'd3, VRA, VRB, 1'b1);
    step(mk(128'h007F0008000100010001000100010001, 7'd3, 1'b1, 1'b1, "ver_avgb"));
    set_in(T_ABSDB, 3'b000, 7'd3, VRA, VRB, 1'b1);
    step(mk(128'h00F8000F000000000000000000000000, 7'd3, 1'b1, 1'b1, "ver_absdb"));
    set_in(T_SUMB, 3'b000, 7'd3, VRA, VRB, 1'b1);
    if (SUMB_ON)
      step(mk(128'h00FB0012000200020002000200020002, 7'd3, 1'b1, 1'b1, "ver_sumb"));
    else
      step(mk('0, '0, 1'b0, 1'b0, "ver_sumb_off"));

    set_in(11'd0, 3'b000, 7'd5, VRA, VRB, 1'b1);
    step(mk('0, '0, 1'b0, 1'b0, "ver_nop"));
    set_in(T_CNTB, 3'b001, 7'd5, VRA, VRB, 1'b1);
    step(mk('0, '0, 1'b0, 1'b0, "ver_fmt"));

    set_in(T_ABSDB, 3'b000, 7'd9, ONES, '0, 1'b1);
    step(mk(ONES, 7'd9, 1'b1, 1'b1, "bnd_absdb"));
    set_in(T_AVGB, 3'b000, 7'd10, ONES, ONES, 1'b1);
    step(mk(ONES, 7'd10, 1'b1, 1'b1, "bnd_avgb"));
    set_in(T_CNTB, 3'b000, 7'd127, ONES, '0, 1'b0);
    step(mk({16{8'h08}}, 7'd127, 1'b0, 1'b1, "bnd_cntb_nowr"));
    set_in(T_SUMB, 3'b000, 7'd11, ONES, ONES, 1'b1);
    if (SUMB_ON) step(mk({8{16'h03FC}}, 7'd11, 1'b1, 1'b1, "bnd_sumb"));
    else         step(mk('0, '0, 1'b0, 1'b0, "bnd_sumb_off"));

    set_in(T_CNTB, 3'b000, 7'd20, VRA, VRB, 1'b1);
    model_step("pre_flush0");
    set_in(T_AVGB, 3'b000, 7'd21, VRA, VRB, 1'b1);
    model_step("pre_flush1");
    reset_step("flush");
    reset = 1'b1;
    set_in(T_ABSDB, 3'b000, 7'd22, VRA, VRB, 1'b1);
    model_step("post_flush");

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: ro = T_CNTB;
        1: ro = T_AVGB;
        2: ro = T_ABSDB;
        3: ro = T_SUMB;
        4: ro = 11'($urandom_range(0, 2047));
        default: ro = 11'd0;
      endcase
      rf = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rx = {$urandom, $urandom, $urandom, $urandom};
      ry = {$urandom, $urandom, $urandom, $urandom};
      set_in(ro, rf, 7'($urandom_range(0, 127)), rx, ry, 1'($urandom_range(0, 1)));
      model_step("rand");
    end

    for (int n = 0; n < LAT; n++) begin
      set_in(11'd0, 3'b000, '0, '0, '0, 1'b0);
      model_step("drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
